// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel button synchroniser, debouncer, press/release pulses, long-press and auto-repeat
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_btn        raw asynchronous button levels, 1 = pressed
//   i_repeat_en  per-channel auto-repeat enable, sampled only in repeat slots
//   o_level      debounced button level
//   o_press      1-cycle pulse on a debounced press and on each repeat
//   o_release    1-cycle pulse on a debounced release
//   o_long       high while the button has been held at least REPEAT_DELAY cycles
module button_conditioner #(
    parameter int N_CH          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CYC  = 16,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn,
    input  logic [N_CH-1:0] i_repeat_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long
);
    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
    localparam logic [DW-1:0] D_MAX    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] H_TOP    = HW'(REPEAT_DELAY);
    // Modular reload: counting up REPEAT_PERIOD steps from here lands exactly on H_TOP.
    localparam logic [HW-1:0] H_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync;
            logic [DW-1:0]          dcnt;
            logic [HW-1:0]          hcnt;
            logic                   lvl, press, rel, lng;
            logic                   s, lvl_nx, slot;
            always_comb begin
                s      = sync[SYNC_STAGES-1];
                lvl_nx = (s != lvl && dcnt == D_MAX) ? s : lvl;
                // A repeat slot only exists while the level stays high; a release wins.
                slot   = lvl & lvl_nx & (hcnt + HW'(1) == H_TOP);
            end
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sync  <= '0;
                    dcnt  <= '0;
                    hcnt  <= '0;
                    lvl   <= 1'b0;
                    press <= 1'b0;
                    rel   <= 1'b0;
                    lng   <= 1'b0;
                end else begin
                    sync  <= {sync[SYNC_STAGES-2:0], i_btn[c]};
                    dcnt  <= (s == lvl || dcnt == D_MAX) ? '0 : dcnt + DW'(1);
                    lvl   <= lvl_nx;
                    press <= (~lvl & lvl_nx) | (slot & i_repeat_en[c]);
                    rel   <= lvl & ~lvl_nx;
                    lng   <= lvl_nx & (lng | slot);
                    hcnt  <= (lvl & lvl_nx) ? (slot ? H_RELOAD : hcnt + HW'(1)) : '0;
                end
            end
            assign o_level[c]   = lvl;
            assign o_press[c]   = press;
            assign o_release[c] = rel;
            assign o_long[c]    = lng;
        end
    endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: self-checking bench for button_conditioner
module tb_button_conditioner;
    localparam int N    = 5;
    localparam int SS   = 2;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int LAT  = SS + DB - 1;
    localparam int MAXT = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn, ren, lv, pr, rl, lg;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_repeat_en(ren),
        .o_level(lv), .o_press(pr), .o_release(rl), .o_long(lg)
    );

    typedef struct {
        int ch;
        int on;
        int off;
        bit hold;
    } ep_t;

    typedef struct {
        logic [N-1:0] lv;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] lg;
    } exp_t;

    ep_t          eps[$];
    exp_t         sb[$];
    logic [N-1:0] e_lv[MAXT], e_pr[MAXT], e_rl[MAXT], e_lg[MAXT];
    logic [N-1:0] ren_m;
    int           rst_s, rst_e;
    int           errors = 0;
    int           checks = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic set_bit(int t, int ch, int kind);
        if (t >= 0 && t < MAXT) begin
            case (kind)
                0: e_lv[t][ch] = 1'b1;
                1: e_pr[t][ch] = 1'b1;
                2: e_rl[t][ch] = 1'b1;
                default: e_lg[t][ch] = 1'b1;
            endcase
        end
    endtask

    // Expected outputs from the timing rules: press LAT edges after the first high
    // sample, long and first repeat RD edges later, repeats every RP, a reset window
    // cuts the episode short and a still-held button re-presses after it.
    task automatic model();
        for (int t = 0; t < MAXT; t++) begin
            e_lv[t] = '0; e_pr[t] = '0; e_rl[t] = '0; e_lg[t] = '0;
        end
        foreach (eps[i]) begin
            if (eps[i].hold) begin
                int  s_on;
                bit  again;
                s_on  = eps[i].on;
                again = 1'b1;
                while (again) begin
                    int p, r, cut;
                    again = 1'b0;
                    p   = s_on + LAT;
                    r   = eps[i].off + LAT;
                    cut = r;
                    if (rst_s > s_on && rst_s < r) begin
                        cut   = rst_s;
                        again = eps[i].off > rst_e;
                    end
                    for (int t = p; t < cut; t++) begin
                        set_bit(t, eps[i].ch, 0);
                        if (t == p) set_bit(t, eps[i].ch, 1);
                        if (t >= p + RD) begin
                            set_bit(t, eps[i].ch, 3);
                            if (ren_m[eps[i].ch] && (t - p - RD) % RP == 0) set_bit(t, eps[i].ch, 1);
                        end
                    end
                    if (cut == r) set_bit(r, eps[i].ch, 2);
                    s_on = rst_e;
                end
            end
        end
    endtask

    task automatic chk(string nm, int t, logic [N-1:0] got, logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0d got=%b expected=%b", nm, t, got, want);
        end
    endtask

    task automatic run(int len, logic [N-1:0] pre);
        model();
        for (int t = -3; t < len; t++) begin
            exp_t         x;
            logic [N-1:0] b;
            b = (t < 0) ? pre : '0;
            if (t >= 0) foreach (eps[i]) if (t >= eps[i].on && t < eps[i].off) b[eps[i].ch] = 1'b1;
            rst = (t < 0) || (t >= rst_s && t < rst_e);
            btn = b;
            ren = ren_m;
            if (t < 0) x = '{default: '0};
            else       x = '{e_lv[t], e_pr[t], e_rl[t], e_lg[t]};
            sb.push_back(x);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk("o_level",   t, lv, x.lv);
            chk("o_press",   t, pr, x.pr);
            chk("o_release", t, rl, x.rl);
            chk("o_long",    t, lg, x.lg);
        end
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        ren = '0;

        // Reset with all held, clean press/release, bounce, repeat, release on a repeat slot.
        eps.delete();
        for (int c = 0; c < N; c++) eps.push_back('{c, 0, 6, 1'b1});
        eps.push_back('{0, 20, 28, 1'b1});
        eps.push_back('{1, 20, 23, 1'b0});
        eps.push_back('{1, 24, 26, 1'b0});
        eps.push_back('{1, 27, 60, 1'b1});
        eps.push_back('{2, 40, 60, 1'b1});
        eps.push_back('{2, 80, 93, 1'b1});
        ren_m = 5'b00100;
        rst_s = 1000;
        rst_e = 1000;
        run(110, 5'h1F);

        // Staggered channels 3/4, reset mid-hold, fresh press afterwards.
        eps.delete();
        eps.push_back('{3, 5, 60, 1'b1});
        eps.push_back('{4, 7, 40, 1'b1});
        ren_m = 5'b01000;
        rst_s = 21;
        rst_e = 24;
        run(75, 5'h00);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
